// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Hazard unit for a five-stage in-order pipeline (IF/ID/EX/MEM/WB). It
// combines three concerns:
//   * operand forwarding into EX (combinational mux selects),
//   * load-use stalls and taken-branch/jump flushes of the front end,
//   * a pipeline-wide freeze while a data-memory access is outstanding,
//     with a wait-cycle timeout that aborts the access and latches an error.
// It also keeps a saturating count of cycles in which the PC did not advance.
//
// State table
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   RUN      | normal flow; a MEM access without ready freezes and enters
//            | MEM_WAIT with the wait counter loaded to 1
//   MEM_WAIT | access outstanding; frozen until dmem_ready, or until the wait
//            | counter reaches MEM_TIMEOUT (abort, mem_error set, back to RUN)
//
// Parameters
//   MEM_TIMEOUT  8-bit wait-counter value at which an access is abandoned
//   CNT_W        width of stall_count
//
// Ports
//   clk             in   clock, all state updates on the rising edge
//   reset           in   asynchronous, active-high reset
//   id_rs1/id_rs2   in   source registers of the instruction in ID
//   idex_rs1/rs2    in   source registers of the instruction in EX
//   idex_rd         in   destination register in EX
//   idex_memread    in   EX instruction is a load
//   exmem_rd        in   destination register in MEM
//   exmem_regwrite  in   MEM instruction writes the register file
//   memwb_rd        in   destination register in WB
//   memwb_regwrite  in   WB instruction writes the register file
//   branch_taken    in   branch in ID resolved taken
//   jump            in   jump/call/return in ID
//   dmem_req        in   MEM stage accesses data memory this cycle
//   dmem_ready      in   data memory completes the access this cycle
//   stat_clr        in   synchronous clear of stall_count
//   stall           out  load-use stall to the control unit
//   pc_write        out  PC update enable
//   ifid_write      out  IF/ID update enable
//   ifid_flush      out  zero IF/ID on the next edge
//   idex_bubble     out  load a NOP into ID/EX on the next edge
//   freeze          out  hold ID/EX, EX/MEM and MEM/WB
//   fwd_a/fwd_b     out  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   mem_error       out  sticky memory-timeout flag, cleared only by reset
//   stall_count     out  saturating count of cycles with pc_write=0
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id_rs1,
  input  logic [2:0]       id_rs2,
  input  logic [2:0]       idex_rs1,
  input  logic [2:0]       idex_rs2,
  input  logic [2:0]       idex_rd,
  input  logic             idex_memread,
  input  logic [2:0]       exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [2:0]       memwb_rd,
  input  logic             memwb_regwrite,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             stat_clr,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazState_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  hazState_e  state;
  hazState_e  nextState;
  logic [7:0] waitCnt;
  logic [7:0] waitCntNext;
  logic       setError;
  logic       timeout;
  logic       loadUse;
  logic       exmemHit;
  logic       memwbHit;

  // Abort is decided in the cycle the counter sits at the limit, so freeze
  // is already released in that cycle rather than one cycle later.
  assign timeout = (state == MEM_WAIT) && !dmem_ready && (waitCnt >= MEM_TIMEOUT);

  // R0 is hard-wired zero: a load into it never creates a dependency.
  assign loadUse = idex_memread && (idex_rd != 3'd0) &&
                   ((idex_rd == id_rs1) || (idex_rd == id_rs2));

  assign exmemHit = exmem_regwrite && (exmem_rd != 3'd0);
  assign memwbHit = memwb_regwrite && (memwb_rd != 3'd0);

  // State register, wait counter, sticky error and stall statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      waitCnt     <= 8'd0;
      mem_error   <= 1'b0;
      stall_count <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= waitCntNext;
      if (setError) begin
        mem_error <= 1'b1;
      end
      if (stat_clr) begin
        stall_count <= '0;
      end else if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    nextState   = state;
    waitCntNext = waitCnt;
    setError    = 1'b0;
    unique case (state)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          nextState   = MEM_WAIT;
          waitCntNext = 8'd1;
        end else begin
          waitCntNext = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          nextState   = RUN;
          waitCntNext = 8'd0;
        end else if (timeout) begin
          nextState   = RUN;
          waitCntNext = 8'd0;
          setError    = 1'b1;
        end else begin
          waitCntNext = waitCnt + 8'd1;
        end
      end
      default: begin
        nextState   = RUN;
        waitCntNext = 8'd0;
      end
    endcase
  end

  // Output logic. Freeze dominates, then load-use, then branch/jump; a
  // redirect held across a freeze is therefore taken in the first free cycle.
  always_comb begin
    freeze      = 1'b0;
    stall       = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    fwd_a       = FWD_REG;
    fwd_b       = FWD_REG;

    unique case (state)
      RUN:      freeze = dmem_req && !dmem_ready;
      MEM_WAIT: freeze = !dmem_ready && !timeout;
      default:  freeze = 1'b0;
    endcase

    if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (loadUse) begin
      stall       = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (branch_taken || jump) begin
      ifid_flush = 1'b1;
    end

    // The younger result (EX/MEM) wins over MEM/WB when both match.
    if (exmemHit && (exmem_rd == idex_rs1)) begin
      fwd_a = FWD_EXMEM;
    end else if (memwbHit && (memwb_rd == idex_rs1)) begin
      fwd_a = FWD_MEMWB;
    end

    if (exmemHit && (exmem_rd == idex_rs2)) begin
      fwd_b = FWD_EXMEM;
    end else if (memwbHit && (memwb_rd == idex_rs2)) begin
      fwd_b = FWD_MEMWB;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic idex_memread, exmem_regwrite, memwb_regwrite;
  logic branch_taken, jump, dmem_req, dmem_ready, stat_clr;
  logic stall, pc_write, ifid_write, ifid_flush, idex_bubble, freeze, mem_error;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    logic stall, pcw, ifw, flush, bubble, frz, err;
    logic [1:0] fa, fb;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sbq[$];

  pipeline_hazard_controller #(.MEM_TIMEOUT(8'd4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .jump(jump),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .stat_clr(stat_clr),
    .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .freeze(freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_error(mem_error), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clearIn();
    id_rs1 = 0; id_rs2 = 0; idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0;
    exmem_rd = 0; memwb_rd = 0; idex_memread = 0; exmem_regwrite = 0;
    memwb_regwrite = 0; branch_taken = 0; jump = 0; dmem_req = 0;
    dmem_ready = 0; stat_clr = 0;
  endtask

  task automatic cmp1(string tag, string what, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %b expected %b", tag, what, obs, exp);
    end
  endtask

  task automatic cmpN(string tag, string what, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %0d expected %0d", tag, what, obs, exp);
    end
  endtask

  // Push the expectation for the current cycle, then sample 1 time unit later
  // (well clear of the rising edge) and compare against the popped entry.
  task automatic expectOut(string tag, logic st, logic pcw, logic ifw, logic fl,
                           logic bub, logic frz, logic [1:0] fa, logic [1:0] fb,
                           logic err, int cnt);
    exp_t e;
    e.tag = tag; e.stall = st; e.pcw = pcw; e.ifw = ifw; e.flush = fl;
    e.bubble = bub; e.frz = frz; e.fa = fa; e.fb = fb; e.err = err;
    e.cnt = CNT_W'(cnt);
    sbq.push_back(e);
    #1;
    checks++;
    assert (sbq.size() > 0) else begin
      errors++;
      $error("FAIL %s.scoreboard observed empty expected entry", tag);
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp1(e.tag, "stall", stall, e.stall);
      cmp1(e.tag, "pc_write", pc_write, e.pcw);
      cmp1(e.tag, "ifid_write", ifid_write, e.ifw);
      cmp1(e.tag, "ifid_flush", ifid_flush, e.flush);
      cmp1(e.tag, "idex_bubble", idex_bubble, e.bubble);
      cmp1(e.tag, "freeze", freeze, e.frz);
      cmpN(e.tag, "fwd_a", 8'(fwd_a), 8'(e.fa));
      cmpN(e.tag, "fwd_b", 8'(fwd_b), 8'(e.fb));
      cmp1(e.tag, "mem_error", mem_error, e.err);
      cmpN(e.tag, "stall_count", 8'(stall_count), 8'(e.cnt));
    end
  endtask

  initial begin
    clearIn();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    expectOut("reset_idle", 0,1,1,0,0,0, 2'b00,2'b00, 0, 0);

    // Forwarding: EX/MEM beats MEM/WB, rs2 = R0
    @(negedge clk); clearIn();
    exmem_regwrite = 1; exmem_rd = 2; memwb_regwrite = 1; memwb_rd = 2;
    idex_rs1 = 2; idex_rs2 = 0;
    expectOut("fwd_exmem", 0,1,1,0,0,0, 2'b01,2'b00, 0, 0);

    @(negedge clk); clearIn();
    memwb_regwrite = 1; memwb_rd = 5; idex_rs1 = 5; idex_rs2 = 5;
    expectOut("fwd_memwb", 0,1,1,0,0,0, 2'b10,2'b10, 0, 0);

    @(negedge clk); clearIn();
    exmem_regwrite = 1; exmem_rd = 0; memwb_regwrite = 1; memwb_rd = 0;
    expectOut("fwd_r0", 0,1,1,0,0,0, 2'b00,2'b00, 0, 0);

    @(negedge clk); clearIn();
    exmem_regwrite = 0; exmem_rd = 3; memwb_regwrite = 1; memwb_rd = 4;
    idex_rs1 = 3; idex_rs2 = 4;
    expectOut("fwd_nowrite", 0,1,1,0,0,0, 2'b00,2'b10, 0, 0);

    // Load-use stall and its release
    @(negedge clk); clearIn();
    idex_memread = 1; idex_rd = 3; id_rs2 = 3;
    expectOut("lu_stall", 1,0,0,0,1,0, 2'b00,2'b00, 0, 0);

    @(negedge clk); clearIn();
    id_rs2 = 3;
    expectOut("lu_release", 0,1,1,0,0,0, 2'b00,2'b00, 0, 1);

    // Load-use overrides a taken branch
    @(negedge clk); clearIn();
    idex_memread = 1; idex_rd = 6; id_rs1 = 6; branch_taken = 1;
    expectOut("lu_over_branch", 1,0,0,0,1,0, 2'b00,2'b00, 0, 1);

    // Load into R0 never stalls
    @(negedge clk); clearIn();
    idex_memread = 1; idex_rd = 0; id_rs1 = 0;
    expectOut("lu_r0", 0,1,1,0,0,0, 2'b00,2'b00, 0, 2);

    @(negedge clk); clearIn();
    branch_taken = 1;
    expectOut("branch_flush", 0,1,1,1,0,0, 2'b00,2'b00, 0, 2);

    // Memory freeze for three cycles with a jump held throughout
    @(negedge clk); clearIn();
    dmem_req = 1; jump = 1;
    expectOut("freeze1", 0,0,0,0,0,1, 2'b00,2'b00, 0, 2);

    @(negedge clk); clearIn();
    dmem_req = 1; jump = 1; idex_memread = 1; idex_rd = 3; id_rs1 = 3;
    expectOut("freeze2_lu", 0,0,0,0,0,1, 2'b00,2'b00, 0, 3);

    @(negedge clk); clearIn();
    dmem_req = 1; jump = 1;
    expectOut("freeze3", 0,0,0,0,0,1, 2'b00,2'b00, 0, 4);

    @(negedge clk); clearIn();
    dmem_req = 1; dmem_ready = 1; jump = 1;
    expectOut("freeze_release", 0,1,1,1,0,0, 2'b00,2'b00, 0, 5);

    @(negedge clk); clearIn();
    expectOut("after_wait", 0,1,1,0,0,0, 2'b00,2'b00, 0, 5);

    // stat_clr wins over a concurrent increment
    @(negedge clk); clearIn();
    stat_clr = 1; idex_memread = 1; idex_rd = 1; id_rs1 = 1;
    expectOut("clr_with_lu", 1,0,0,0,1,0, 2'b00,2'b00, 0, 5);

    @(negedge clk); clearIn();
    expectOut("clr_done", 0,1,1,0,0,0, 2'b00,2'b00, 0, 0);

    // Saturation of stall_count
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); clearIn();
      idex_memread = 1; idex_rd = 2; id_rs2 = 2;
      expectOut($sformatf("sat_%0d", i), 1,0,0,0,1,0, 2'b00,2'b00, 0, (i > 15) ? 15 : i);
    end

    @(negedge clk); clearIn();
    stat_clr = 1;
    expectOut("sat_clr", 0,1,1,0,0,0, 2'b00,2'b00, 0, 15);

    @(negedge clk); clearIn();
    expectOut("sat_cleared", 0,1,1,0,0,0, 2'b00,2'b00, 0, 0);

    // Timeout with MEM_TIMEOUT = 4 and memory never ready
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); clearIn();
      dmem_req = 1;
      expectOut($sformatf("to_wait_%0d", i), 0,0,0,0,0,1, 2'b00,2'b00, 0, i);
    end

    @(negedge clk); clearIn();
    dmem_req = 1;
    expectOut("to_abort", 0,1,1,0,0,0, 2'b00,2'b00, 0, 4);

    // Back in RUN: with ready low and no request there is no freeze
    @(negedge clk); clearIn();
    expectOut("to_run_err", 0,1,1,0,0,0, 2'b00,2'b00, 1, 4);

    // Re-enter MEM_WAIT, then reset asynchronously mid-wait
    @(negedge clk); clearIn();
    dmem_req = 1;
    expectOut("rst_enter", 0,0,0,0,0,1, 2'b00,2'b00, 1, 4);

    @(negedge clk); clearIn();
    dmem_req = 1;
    expectOut("rst_midwait", 0,0,0,0,0,1, 2'b00,2'b00, 1, 5);
    reset = 1'b1;
    expectOut("rst_async", 0,0,0,0,0,1, 2'b00,2'b00, 0, 0);

    @(negedge clk); clearIn();
    reset = 1'b0;
    expectOut("rst_after", 0,1,1,0,0,0, 2'b00,2'b00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 8'd255, giving the maximum number of MEM_WAIT cycles before abort.
REQ-002 SHALL provide parameter CNT_W, default 16, giving the stall_count width.
REQ-003 SHALL use a single clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 id_rs1  in  3  source register 1 of the instruction in ID.
REQ-007 id_rs2  in  3  source register 2 of the instruction in ID.
REQ-008 idex_rs1  in  3  source register 1 in EX.
REQ-009 idex_rs2  in  3  source register 2 in EX.
REQ-010 idex_rd  in  3  destination register in EX.
REQ-011 idex_memread  in  1  EX instruction is LW/LB.
REQ-012 exmem_rd  in  3  destination register in MEM.
REQ-013 exmem_regwrite  in  1  MEM instruction writes the register file.
REQ-014 memwb_rd  in  3  destination register in WB.
REQ-015 memwb_regwrite  in  1  WB instruction writes the register file.
REQ-016 branch_taken  in  1  branch in ID resolved taken (PCSrc=01).
REQ-017 jump  in  1  JMP/CALL/RET in ID (PCSrc=10/11).
REQ-018 dmem_req  in  1  MEM stage accesses data memory this cycle.
REQ-019 dmem_ready  in  1  data memory completes the access this cycle.
REQ-020 stat_clr  in  1  synchronous clear of stall_count.
REQ-021 stall  out  1  load-use stall; drives the stall input of signalsControlUnit.
REQ-022 pc_write  out  1  PC register update enable.
REQ-023 ifid_write  out  1  IF/ID register update enable.
REQ-024 ifid_flush  out  1  zero the IF/ID register on the next edge.
REQ-025 idex_bubble  out  1  load a NOP into ID/EX on the next edge.
REQ-026 freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers.
REQ-027 fwd_a  out  2  EX operand A source: 00 register file, 01 EX/MEM, 10 MEM/WB.
REQ-028 fwd_b  out  2  EX operand B source, same encoding as fwd_a.
REQ-029 mem_error  out  1  sticky flag set when a memory access times out.
REQ-030 stall_count  out  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-031 FSM SHALL have two states, RUN and MEM_WAIT, plus an 8-bit wait counter.
REQ-032 Forwarding SHALL be combinational:
- fwd_a=01 when exmem_regwrite, exmem_rd!=0 and exmem_rd==idex_rs1.
- Otherwise fwd_a=10 when memwb_regwrite, memwb_rd!=0 and memwb_rd==idex_rs1.
- Otherwise fwd_a=00.
- fwd_b uses the same rules with idex_rs2.
REQ-033 Load-use hazard (lu) SHALL be defined as idex_memread, idex_rd!=0 and idex_rd equal to id_rs1 or id_rs2; register R0 never stalls and is never forwarded.
REQ-034 Freeze condition SHALL be:
- In RUN: freeze=1 when dmem_req=1 and dmem_ready=0.
- In MEM_WAIT: freeze=1 while dmem_ready=0.
- freeze SHALL force pc_write=0, ifid_write=0, stall=0, idex_bubble=0 and ifid_flush=0.
REQ-035 When not frozen and lu=1, the block SHALL assert, in the same cycle: stall=1, pc_write=0, ifid_write=0, idex_bubble=1 and ifid_flush=0 (lu overrides branch/jump).
REQ-036 When not frozen, lu=0 and (branch_taken or jump)=1, the block SHALL assert ifid_flush=1 with pc_write=1 in the same cycle.
REQ-037 In all other cases: pc_write=1, ifid_write=1, all other control outputs 0.
REQ-038 State transitions:
- RUN->MEM_WAIT when dmem_req=1 and dmem_ready=0; wait counter loads 1.
- MEM_WAIT->RUN on dmem_ready=1; freeze drops in that same cycle.
- In MEM_WAIT, the wait counter increments each cycle.
- When the wait counter reaches MEM_TIMEOUT: set mem_error, go to RUN, release freeze.
REQ-039 mem_error SHALL stay set until reset.
REQ-040 stall_count SHALL increment each cycle pc_write=0 and saturate at all-ones.
REQ-041 stat_clr SHALL zero stall_count and take precedence over the increment.
REQ-042 A branch or jump presented during freeze SHALL be acted on only in the first unfrozen cycle.

Reset
REQ-043 Reset SHALL set state=RUN, wait counter=0, mem_error=0 and stall_count=0 immediately, mid-wait included.
REQ-044 With inputs idle after reset: pc_write=1, ifid_write=1, all other outputs 0.

Verification
REQ-045 idex_memread=1, idex_rd=3, id_rs2=3 -> that cycle: stall=1, pc_write=0, idex_bubble=1; next cycle (idex_memread=0): pc_write=1; stall_count=1.
REQ-046 exmem_regwrite=1, exmem_rd=2, memwb_regwrite=1, memwb_rd=2, idex_rs1=2, idex_rs2=0 -> fwd_a=01, fwd_b=00.
REQ-047 dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 -> freeze=1 for 3 cycles, 0 on the ready cycle; stall_count=3.
REQ-048 jump=1 during freeze, held -> ifid_flush=0 while frozen, 1 on the release cycle.
REQ-049 MEM_TIMEOUT=4, dmem_ready stuck at 0 -> mem_error=1 after 4 wait cycles; state RUN; assert reset -> mem_error=0 asynchronously.
